// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter fed by a valid/ready input FIFO
module uart_tx_param #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0] DATA_END = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_END = 4'(STOP_BITS - 1);
    localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);
    localparam logic ODD = PARITY == 1;
    localparam logic HAS_PARITY = PARITY != 0;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] PAR   = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [DATA_BITS-1:0] head;
    logic [DATA_BITS-1:0] shift;
    logic [2:0]           state;
    logic [CW-1:0]        bit_cnt;
    logic [3:0]           bit_idx;
    logic                 par_bit;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 bit_end;
    logic                 data_last;
    logic                 stop_last;
    logic                 frame_end;

    assign head      = mem[rd_ptr];
    assign full      = fifo_count == FULL_COUNT;
    assign empty     = fifo_count == '0;
    assign tx_ready  = ~full;
    assign push      = tx_valid & ~full;
    assign bit_end   = bit_cnt == BIT_END;
    assign data_last = bit_idx == DATA_END;
    assign stop_last = bit_idx == STOP_END;
    assign frame_end = state == STOP && bit_end && stop_last;
    assign pop       = ~empty & (state == IDLE | frame_end);
    assign busy      = state != IDLE | ~empty;

    // FIFO storage; entries are only read after being written, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    // FIFO pointers and occupancy; a push and a pop on one edge leave the count unchanged
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_count <= fifo_count + NW'(push) - NW'(pop);
        end
    end

    // frame sequencer: bit timer, bit index and payload shifter; a pop in the last stop cycle chains frames
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else if (pop) begin
            state   <= START;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= head;
            par_bit <= ^head ^ ODD;
        end else if (state != IDLE) begin
            bit_cnt <= bit_end ? '0 : bit_cnt + CW'(1);
            if (bit_end) begin
                case (state)
                    START: state <= DATA;
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_idx <= data_last ? '0 : bit_idx + 4'd1;
                        if (data_last) state <= HAS_PARITY ? PAR : STOP;
                    end
                    PAR: state <= STOP;
                    STOP: begin
                        bit_idx <= stop_last ? '0 : bit_idx + 4'd1;
                        if (stop_last) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // line driver registered from the sequencer state so tx never glitches; it trails the state by one clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tx <= 1'b1;
        else tx <= state == START ? 1'b0 : state == DATA ? shift[0] : state == PAR ? par_bit : 1'b1;
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: scoreboard bench for three uart_tx_param configurations sharing one clock
module tb_uart_tx_param;
    localparam int CPB = 8;
    localparam int LIM = 2000;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  vld;
    logic [2:0]  rdy;
    logic [2:0]  txl;
    logic [2:0]  bsy;
    logic [8:0]  din [3];
    logic [2:0]  cnt [3];
    logic [9:0]  exp_q [3][$];
    int          starts [3][$];
    int          rst_ev [3];
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // u0: 8N1, u1: 8 bits even parity, u2: 7 bits odd parity 2 stop; all 8 clocks per bit
    for (genvar g = 0; g < 3; g++) begin : gen_dut
        localparam int W  = g == 2 ? 7 : 8;
        localparam int PM = g == 0 ? 0 : g == 1 ? 2 : 1;
        localparam int SB = g == 2 ? 2 : 1;

        uart_tx_param #(
            .CLK_FREQ(80), .BAUD(10), .DATA_BITS(W), .PARITY(PM), .STOP_BITS(SB), .FIFO_DEPTH(4)
        ) dut (
            .clk(clk),
            .reset(rst[g]),
            .tx_data(din[g][W-1:0]),
            .tx_valid(vld[g]),
            .tx_ready(rdy[g]),
            .tx(txl[g]),
            .busy(bsy[g]),
            .fifo_count(cnt[g])
        );

        // monitor: decode each frame mid-bit and compare against the head of the expected queue
        initial begin : mon
            logic [8:0] d;
            logic [1:0] st;
            logic       s0;
            logic       p;
            logic [9:0] e;
            int         ev;
            forever begin
                @(negedge txl[g]);
                ev = rst_ev[g];
                starts[g].push_back(cyc);
                repeat (CPB / 2) @(posedge clk);
                #1 s0 = txl[g];
                d = '0;
                p = 1'b0;
                st = 2'b11;
                for (int i = 0; i < W; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1 d[i] = txl[g];
                end
                if (PM != 0) begin
                    repeat (CPB) @(posedge clk);
                    #1 p = txl[g];
                end
                for (int i = 0; i < SB; i++) begin
                    repeat (CPB) @(posedge clk);
                    #1 st[i] = txl[g];
                end
                if (ev == rst_ev[g]) begin
                    if (exp_q[g].size() == 0) chk($sformatf("mon%0d unexpected frame", g), exp_q[g].size(), 1);
                    else begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("mon%0d start bit", g), s0, 0);
                        chk($sformatf("mon%0d data+parity", g), {p, d}, e);
                        chk($sformatf("mon%0d stop bits", g), st, 2'b11);
                    end
                end
            end
        end
    end

    task automatic wr(input int g, input logic [8:0] d, input logic [9:0] e, input bit keep);
        int n;
        exp_q[g].push_back(e);
        @(negedge clk);
        din[g] = d;
        vld[g] = 1'b1;
        n = 0;
        while (!rdy[g] && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept u%0d", g), rdy[g], 1);
        @(posedge clk);
        #1 if (!keep) vld[g] = 1'b0;
    endtask

    task automatic wait_idle(input int g);
        int n;
        n = 0;
        while (bsy[g] && n < LIM) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("idle u%0d", g), bsy[g], 0);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c2;
        int lows;
        rst = 3'b111;
        vld = '0;
        for (int i = 0; i < 3; i++) begin
            din[i] = '0;
            rst_ev[i] = 0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset tx u%0d", g), txl[g], 1);
            chk($sformatf("reset ready u%0d", g), rdy[g], 1);
            chk($sformatf("reset busy u%0d", g), bsy[g], 0);
            chk($sformatf("reset count u%0d", g), cnt[g], 0);
        end
        rst = '0;
        repeat (2) @(negedge clk);

        // single 8N1 frame: latency and busy window
        wr(0, 9'h031, 10'h031, 0);
        chk("t1 count after accept", cnt[0], 1);
        chk("t1 busy after accept", bsy[0], 1);
        @(posedge clk);
        #1 chk("t1 tx at pop edge", txl[0], 1);
        @(posedge clk);
        #1 chk("t1 tx falls 2 after accept", txl[0], 0);
        n = 2;
        while (bsy[0] && n < LIM) begin
            @(posedge clk);
            #1 n++;
        end
        chk("t1 busy clocks", n, 81);
        wait_idle(0);

        // even parity
        wr(1, 9'h031, 10'h231, 0);
        wr(1, 9'h0FF, 10'h0FF, 0);
        wait_idle(1);

        // 7 data bits, odd parity, 2 stop bits
        starts[2].delete();
        wr(2, 9'h055, 10'h255, 0);
        wr(2, 9'h031, 10'h031, 0);
        wait_idle(2);
        chk("t3 frame count", starts[2].size(), 2);
        chk("t3 frame clocks", starts[2][1] - starts[2][0], 88);

        // burst of six with valid held high
        starts[0].delete();
        wr(0, 9'h0A5, 10'h0A5, 1);
        wr(0, 9'h03C, 10'h03C, 1);
        wr(0, 9'h001, 10'h001, 1);
        wr(0, 9'h080, 10'h080, 1);
        wr(0, 9'h0FF, 10'h0FF, 1);
        chk("t4 full count", cnt[0], 4);
        chk("t4 ready low when full", rdy[0], 0);
        din[0] = 9'h05A;
        repeat (3) @(negedge clk);
        chk("t4 count held while full", cnt[0], 4);
        chk("t4 ready still low", rdy[0], 0);
        wr(0, 9'h05A, 10'h05A, 0);
        chk("t4 ready low again", rdy[0], 0);
        wait_idle(0);
        chk("t4 frame count", starts[0].size(), 6);
        for (int i = 1; i < 6; i++) chk($sformatf("t4 gap %0d", i), starts[0][i] - starts[0][i-1], 80);

        // write on the same edge as a pop with two queued
        wr(1, 9'h00F, 10'h00F, 0);
        wr(1, 9'h080, 10'h280, 0);
        c2 = cyc;
        chk("t5 pop+write from one", cnt[1], 1);
        wr(1, 9'h003, 10'h003, 0);
        chk("t5 count two", cnt[1], 2);
        exp_q[1].push_back(10'h207);
        while (cyc < c2 + 87) @(negedge clk);
        din[1] = 9'h007;
        vld[1] = 1'b1;
        chk("t5 ready before pop", rdy[1], 1);
        @(posedge clk);
        #1 vld[1] = 1'b0;
        chk("t5 count held at two", cnt[1], 2);
        wait_idle(1);

        // reset mid-frame with two words queued
        wr(2, 9'h000, 10'h000, 0);
        wr(2, 9'h012, 10'h012, 0);
        wr(2, 9'h034, 10'h034, 0);
        chk("t6 queued", cnt[2], 2);
        repeat (20) @(negedge clk);
        chk("t6 tx low in data", txl[2], 0);
        rst[2] = 1'b1;
        rst_ev[2]++;
        exp_q[2].delete();
        #1;
        chk("t6 tx high on reset", txl[2], 1);
        chk("t6 count flushed", cnt[2], 0);
        chk("t6 busy cleared", bsy[2], 0);
        chk("t6 ready on reset", rdy[2], 1);
        repeat (2) @(negedge clk);
        rst[2] = 1'b0;
        lows = 0;
        repeat (200) begin
            @(negedge clk);
            if (!txl[2]) lows++;
        end
        chk("t6 line quiet after reset", lows, 0);
        chk("t6 busy after release", bsy[2], 0);
        wr(2, 9'h055, 10'h255, 0);
        wait_idle(2);

        for (int g = 0; g < 3; g++) chk($sformatf("queue drained u%0d", g), exp_q[g].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 switch-driven transmitter.
- Configurable data width, parity mode, stop-bit count and baud divisor.
- Valid/ready byte input with an internal FIFO, so frames go out back-to-back without gaps.
- Sits between any byte producer (switch capture, CPU, packetiser) and the board TX pin.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate in bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD using integer division (5208 at defaults)
DATA_BITS, 8, payload bits per frame; legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, number of stop bits; 1 or 2
FIFO_DEPTH, 4, input FIFO entries; must be a power of 2, at least 2

Ports:
clk  input  1  system clock; all logic is rising-edge
reset  input  1  asynchronous, active-high reset
tx_data  input  DATA_BITS  payload word
tx_valid  input  1  producer presents tx_data
tx_ready  output  1  FIFO can accept a word (equals not full)
tx  output  1  serial line; idles high
busy  output  1  high when the FSM is not IDLE or the FIFO is not empty
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async assert, sync release):
  - tx = 1, tx_ready = 1, busy = 0, fifo_count = 0.
  - FSM = IDLE; FIFO pointers cleared.
  - Asserting reset mid-frame drops the frame and flushes the FIFO; tx returns high immediately.
- Write handshake:
  - A word is accepted on any rising edge with tx_valid & tx_ready.
  - tx_valid while full is ignored; the producer holds tx_data and tx_valid until accepted.
- Pop (IDLE or frame end):
  - When the FIFO is non-empty, the FSM pops the head word into a shift register and enters START.
  - Pop with simultaneous write: fifo_count unchanged. Write is never accepted when full, even if a pop occurs the same cycle.
- Latency: after an accepting edge into an empty FIFO with the FSM in IDLE, tx falls on the 2nd following rising edge (write, then pop).
- FSM states and transitions:
  - IDLE: tx = 1; go to START on pop.
  - START: tx = 0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each held CLKS_PER_BIT cycles.
  - PARITY: present only if PARITY != 0. Bit = XOR of data bits for even mode, its inverse for odd mode.
  - STOP: tx = 1 for STOP_BITS*CLKS_PER_BIT cycles.
  - On the last STOP cycle, if the FIFO is non-empty, pop and enter START with no idle cycle between frames; else go to IDLE.
- Bit timing: one counter 0..CLKS_PER_BIT-1 advances the bit index on terminal count. Every bit period is exactly CLKS_PER_BIT clocks, with no cumulative drift.
- tx is driven from a register, so there are no glitches.
- Frame length = (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT clocks.
- busy deasserts on the same edge that the FSM enters IDLE with an empty FIFO.

Test Plan:
- Defaults, reset released, one write of 0x31 -> tx levels 0,1,0,0,0,1,1,0,0,1, each 5208 clocks; falling edge 2 clocks after the accept; busy high for 52080+1 clocks.
- PARITY=2 and 0x31 -> parity bit 1 (three ones); PARITY=1 and 0x31 -> parity bit 0. Stop bit follows the parity bit.
- Burst of 6 words with tx_valid held high, FIFO_DEPTH=4:
  - tx_ready low after the FIFO fills, then toggles as frames pop.
  - All 6 frames contiguous: 6*52080 clocks with no idle high gap between stop and start.
  - Word order preserved.
- DATA_BITS=7, STOP_BITS=2, write 0x55 -> 7 data bits 1,0,1,0,1,0,1, then 2*CLKS_PER_BIT high; frame length 10 bit periods.
- Assert reset mid-DATA of frame 1 with 2 words queued:
  - tx high immediately; fifo_count = 0; busy = 0.
  - No further frames after release until a new write.
- Write accepted on the same edge as a pop with fifo_count=2 -> fifo_count stays 2. Write attempted while full -> fifo_count stays 4 and the word is not lost by the producer (tx_ready low).
